stopwatch_datapath: RTL
=======================

STOPWATCH_DATAPATH -- requirements
Module: stopwatch_datapath

Parameters
REQ-001 The block SHALL have parameter TICKS_PER_CS, default 500000, giving clock cycles per centisecond tick; legal range is 2 or more.
REQ-002 The block SHALL have parameter BLINK_HALF, default 25000000, giving clock cycles per blink half-period; legal range is 2 or more.

Interface
REQ-003 clk  input  1  system clock; all state SHALL change on the rising edge only.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  count-run request from the stopwatch control FSM.
REQ-006 clear  input  1  synchronous count-clear request, driven by the control FSM's reset output.
REQ-007 blink  input  2  blink mode from the control FSM: 00 none, 01 low pair, 10 high pair, 11 all digits.
REQ-008 target  input  16  BCD compare value {d3,d2,d1,d0}, i.e. SS.hh.
REQ-009 equal  output  1  registered flag, returned to the control FSM.
REQ-010 digits  output  16  BCD count {d3,d2,d1,d0}; d3 is tens of seconds, d0 is hundredths.
REQ-011 blank  output  4  per-digit blank, bit i blanks digit i.
REQ-012 tick  output  1  one-cycle pulse on each centisecond increment.

Function
REQ-013 Prescaler pc: counts 0..TICKS_PER_CS-1 while enable=1 and clear=0; holds while enable=0.
REQ-014 tick SHALL be 1 in the cycle after the edge at which pc goes from TICKS_PER_CS-1 to 0; otherwise tick SHALL be 0.
REQ-015 On each tick edge, digits SHALL increment by one hundredth in BCD.
- Each digit rolls 9->0 with carry to the next digit.
- The same edge that wraps pc SHALL also update digits.
REQ-016 Saturation: at 99.99 the count SHALL hold, with no wrap. pc keeps running; tick still pulses.
REQ-017 Precedence: clear=1 SHALL set pc=0 and digits=0000 on the next edge, regardless of enable; tick=0 that cycle.
REQ-018 Every digit SHALL always be in 0..9.
REQ-019 equal SHALL be registered: equal <= (digits_next == target), giving one-cycle latency from a target change.
- equal SHALL rise in the same cycle digits shows the matching value.
- A target holding any non-BCD digit SHALL never assert equal.
REQ-020 After clear with target=0000, equal SHALL be 1 (legal).
REQ-021 Blink timer: bc SHALL count 0..BLINK_HALF-1 free-running, independent of enable and clear.
- phase SHALL toggle when bc wraps.
- Reset value: phase=0 (visible).
REQ-022 blank SHALL be combinational from the blink input and phase:
- 00 -> 0000
- 01 -> {2'b00, phase, phase}
- 10 -> {phase, phase, 2'b00}
- 11 -> {4{phase}}
REQ-023 Simultaneous clear and a pc wrap: clear SHALL win, with no increment.
REQ-024 Simultaneous enable fall and a pc wrap: the increment occurs only if enable=1 at that edge.

Reset
REQ-025 While rst=1, regardless of clk, the block SHALL force:
- pc=0, bc=0, phase=0
- digits=0000, equal=0, tick=0
REQ-026 rst SHALL dominate clear and enable.
REQ-027 Deassertion mid-count SHALL resume from zero state on the first edge with rst=0.

Verification (TICKS_PER_CS=4, BLINK_HALF=8)
REQ-028 Count: rst pulse, then enable=1 for 40 cycles -> tick every 4th cycle, digits=00.10 at the 10th tick, equal=0 with target=9999.
REQ-029 Hold: enable 1->0 at pc=2 for 20 cycles, then enable=1 -> digits unchanged while low; next tick 2 cycles after re-enable.
REQ-030 Carry/saturate: preload by running to 09.99 then to 99.99 -> 09.99->10.00 in one tick; at 99.99 further ticks leave digits=9999.
REQ-031 Equal: target=0005, enable=1 -> equal=1 in exactly the cycle digits=0005, 0 at 0006; target=000A -> equal never 1.
REQ-032 Clear precedence: clear=1 and enable=1 at a pc-wrap edge -> digits=0000, tick=0, equal=1 if target=0000.
REQ-033 Blink/reset: blink=01 -> blank toggles 0000/0011 every 8 cycles; rst mid-run -> all outputs 0 immediately, with no clk edge required.

Source files
------------

// File: rtl/stopwatch_datapath.sv
// rtl/stopwatch_datapath.sv - centisecond stopwatch datapath: prescaler, BCD count, compare, blink
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   enable  count-run request
//   clear   synchronous count clear (wins over enable)
//   blink   blink mode: 00 none, 01 low pair, 10 high pair, 11 all
//   target  BCD compare value {d3,d2,d1,d0}
//   equal   registered (next count == target)
//   digits  BCD count {d3,d2,d1,d0}, SS.hh
//   blank   per-digit blank, bit i blanks digit i
//   tick    one-cycle pulse per centisecond increment
module stopwatch_datapath #(
    parameter int TICKS_PER_CS = 500000,
    parameter int BLINK_HALF   = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear,
    input  logic [1:0]  blink,
    input  logic [15:0] target,
    output logic        equal,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic        tick
);

    localparam int PC_W = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
    localparam int BC_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(TICKS_PER_CS - 1);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(BLINK_HALF - 1);

    logic [PC_W-1:0] pc, pc_next;
    logic [BC_W-1:0] bc;
    logic            phase;
    logic [15:0]     digits_inc, digits_next;
    logic            tick_next;
    logic            inc_carry;

    // BCD +1 with ripple carry; the count sticks at 99.99 instead of wrapping.
    always_comb begin
        digits_inc = digits;
        inc_carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (inc_carry) begin
                if (digits[i*4 +: 4] == 4'd9) begin
                    digits_inc[i*4 +: 4] = 4'd0;
                end else begin
                    digits_inc[i*4 +: 4] = digits[i*4 +: 4] + 4'd1;
                    inc_carry = 1'b0;
                end
            end
        end
        if (digits == 16'h9999) begin
            digits_inc = digits;
        end
    end

    // Clear beats everything; the increment rides on the same edge as the pc wrap.
    always_comb begin
        pc_next     = pc;
        digits_next = digits;
        tick_next   = 1'b0;
        if (clear) begin
            pc_next     = '0;
            digits_next = '0;
        end else if (enable) begin
            if (pc == PC_MAX) begin
                pc_next     = '0;
                digits_next = digits_inc;
                tick_next   = 1'b1;
            end else begin
                pc_next = pc + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= '0;
            digits <= '0;
            tick   <= 1'b0;
            equal  <= 1'b0;
        end else begin
            pc     <= pc_next;
            digits <= digits_next;
            tick   <= tick_next;
            // Compare against the next count so equal lines up with digits.
            // digits is always BCD, so a non-BCD target can never match.
            equal  <= (digits_next == target);
        end
    end

    // Free-running blink timer, unaffected by enable/clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bc    <= '0;
            phase <= 1'b0;
        end else if (bc == BC_MAX) begin
            bc    <= '0;
            phase <= ~phase;
        end else begin
            bc <= bc + BC_W'(1);
        end
    end

    assign blank = {blink[1] & phase, blink[1] & phase, blink[0] & phase, blink[0] & phase};

endmodule
